tempsens_seq: RTL and testbench

Initiator side of the delay-timer handshake for the temperature-sensor path. Steps a power-up → convert → read → gap loop, arming the shared delay timer (module `delay`, instantiated beside it in the parent) with a per-phase wait and advancing on its expiry flag. Emits a one-cycle conversion strobe and a level read request towards the sensor read engine. Counts completed samples.

---
 rtl/tempsens_pkg.sv | 19 +
 rtl/tempsens_seq.sv | 155 +++++++++++++++
 tb/tb_tempsens_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tempsens_pkg.sv
// Shared types and widths for the temperature-sensor sequencer.
package tempsens_pkg;

   localparam int WAIT_W   = 23;
   localparam int SAMPLE_W = 16;

   typedef enum logic [3:0] {
      IDLE,
      PWR_ARM,
      PWR_WAIT,
      CONV_ARM,
      CONV_WAIT,
      RD_ARM,
      RD_WAIT,
      GAP_ARM,
      GAP_WAIT
   } seq_state_t;

endpackage

// File: rtl/tempsens_seq.sv
// Temperature-sensor sequencer: power-up -> convert -> read -> gap loop,
// driving the shared delay timer (arm in *_ARM, wait for expiry in *_WAIT).
// Optional macro TEMPSENS_SEQ_RDTO_EN enables the read timeout and the
// sticky rd_err flag; without it RD_WAIT waits on rd_done alone.
module tempsens_seq
   import tempsens_pkg::*;
#(
   parameter logic [WAIT_W-1:0] T_PWRUP = 23'd5_000_000,
   parameter logic [WAIT_W-1:0] T_CONV  = 23'd3_750_000,
   parameter logic [WAIT_W-1:0] T_GAP   = 23'd2_500_000,
   parameter logic [WAIT_W-1:0] T_RDTO  = 23'd1_000_000
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                start,
   input  logic                abort,
   input  logic                timer_xs,
   input  logic                rd_done,
   output logic [WAIT_W-1:0]   timer_wait,
   output logic                timer_rst,
   output logic                conv_start,
   output logic                rd_req,
   output logic                busy,
   output logic                rd_err,
   output logic [SAMPLE_W-1:0] sample_cnt
);

   seq_state_t          state_q, state_d;
   logic                cnt_inc;
   logic [SAMPLE_W-1:0] cnt_q;
`ifdef TEMPSENS_SEQ_RDTO_EN
   logic                err_set, err_clr;
   logic                err_q;
`endif

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and counter/flag update strobes; abort overrides everything
   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;
`ifdef TEMPSENS_SEQ_RDTO_EN
      err_set = 1'b0;
      err_clr = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PWR_ARM;
`ifdef TEMPSENS_SEQ_RDTO_EN
               err_clr = 1'b1;
`endif
            end
         end
         PWR_ARM:   state_d = PWR_WAIT;
         PWR_WAIT:  if (timer_xs) state_d = CONV_ARM;
         CONV_ARM:  state_d = CONV_WAIT;
         CONV_WAIT: if (timer_xs) state_d = RD_ARM;
         RD_ARM:    state_d = RD_WAIT;
         RD_WAIT: begin
            // rd_done wins over a coincident timeout
            if (rd_done) begin
               state_d = GAP_ARM;
               cnt_inc = 1'b1;
            end
`ifdef TEMPSENS_SEQ_RDTO_EN
            else if (timer_xs) begin
               state_d = GAP_ARM;
               err_set = 1'b1;
            end
`endif
         end
         GAP_ARM:   state_d = GAP_WAIT;
         GAP_WAIT:  if (timer_xs) state_d = start ? CONV_ARM : IDLE;
         default:   state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         cnt_inc = 1'b0;
`ifdef TEMPSENS_SEQ_RDTO_EN
         err_set = 1'b0;
         err_clr = 1'b0;
`endif
      end
   end

   // Completed-sample counter, wraps naturally at all-ones
   always_ff @(posedge CLK) begin
      if (!RST_N)       cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
   end

   assign sample_cnt = cnt_q;

`ifdef TEMPSENS_SEQ_RDTO_EN
   // Sticky read-timeout flag, cleared on reset or on a fresh start
   always_ff @(posedge CLK) begin
      if (!RST_N)       err_q <= 1'b0;
      else if (err_clr) err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign rd_err = err_q;
`else
   assign rd_err = 1'b0;
`endif

   // Moore output decode from the state register
   always_comb begin
      timer_wait = '0;
      timer_rst  = 1'b1;
      conv_start = 1'b0;
      rd_req     = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         PWR_ARM:   timer_wait = T_PWRUP;
         PWR_WAIT: begin
            timer_wait = T_PWRUP;
            timer_rst  = 1'b0;
         end
         CONV_ARM: begin
            timer_wait = T_CONV;
            conv_start = 1'b1;
         end
         CONV_WAIT: begin
            timer_wait = T_CONV;
            timer_rst  = 1'b0;
         end
         // Without the timeout the timer stays cleared through the read,
         // so the wait value presented here is inert in that build.
         RD_ARM: begin
            timer_wait = T_RDTO;
            rd_req     = 1'b1;
         end
         RD_WAIT: begin
            timer_wait = T_RDTO;
            rd_req     = 1'b1;
`ifdef TEMPSENS_SEQ_RDTO_EN
            timer_rst  = 1'b0;
`endif
         end
         GAP_ARM:   timer_wait = T_GAP;
         GAP_WAIT: begin
            timer_wait = T_GAP;
            timer_rst  = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tempsens_seq.sv
// Directed bench for tempsens_seq with a behavioural delay-timer model.
// Covers both builds: timeout expectations follow TEMPSENS_SEQ_RDTO_EN.
module tb_tempsens_seq;

   logic        CLK = 1'b0;
   logic        RST_N, start, abort, rd_done;
   logic        timer_xs = 1'b0;
   logic [22:0] timer_wait;
   logic        timer_rst, conv_start, rd_req, busy, rd_err;
   logic [15:0] sample_cnt;
   logic [22:0] tcnt = '0;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_cnt;
   logic exp_err, seen;

   tempsens_seq #(
      .T_PWRUP(23'd4), .T_CONV(23'd3), .T_GAP(23'd2), .T_RDTO(23'd5)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
      .timer_xs(timer_xs), .rd_done(rd_done), .timer_wait(timer_wait),
      .timer_rst(timer_rst), .conv_start(conv_start), .rd_req(rd_req),
      .busy(busy), .rd_err(rd_err), .sample_cnt(sample_cnt)
   );

   always #5 CLK = ~CLK;

   // Delay timer: cleared while timer_rst, flag rises W cycles after clear
   always @(posedge CLK) begin
      if (timer_rst) begin
         tcnt     <= '0;
         timer_xs <= 1'b0;
      end else begin
         tcnt     <= tcnt + 23'd1;
         timer_xs <= ((tcnt + 23'd1) >= timer_wait);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_trst"},  timer_rst, 1);
      chk({tag, "_twait"}, timer_wait, 0);
      chk({tag, "_conv"},  conv_start, 0);
      chk({tag, "_rdreq"}, rd_req, 0);
      chk({tag, "_err"},   rd_err, 0);
      chk({tag, "_cnt"},   sample_cnt, 0);
   endtask

   initial begin
      RST_N = 0; start = 0; abort = 0; rd_done = 0;
      tick(); tick();
      RST_N = 1;
      chk_reset_vals("rst");

      // Full first pass: power-up, convert, read, gap, loop
      start = 1;
      tick();
      chk("pwr_arm_busy", busy, 1);
      chk("pwr_arm_twait", timer_wait, 4);
      chk("pwr_arm_trst", timer_rst, 1);
      seen = 0;
      repeat (5) begin tick(); seen |= conv_start; end
      chk("pwr_wait_trst", timer_rst, 0);
      chk("pwr_no_early_conv", seen, 0);
      tick();
      chk("conv_at_6", conv_start, 1);
      chk("conv_twait", timer_wait, 3);
      tick();
      chk("conv_one_cycle", conv_start, 0);
      repeat (3) tick();
      tick();
      chk("rd_arm_req", rd_req, 1);
      chk("rd_arm_twait", timer_wait, 5);
      tick();
      tick(); rd_done = 1;
      tick(); rd_done = 0;
      exp_cnt = 1;
      chk("cnt_first", sample_cnt, exp_cnt);
      chk("gap_rdreq", rd_req, 0);
      chk("gap_twait", timer_wait, 2);
      tick();
      rd_done = 1; tick(); rd_done = 0;
      chk("stray_rd_done", sample_cnt, exp_cnt);
      tick();
      tick();
      chk("loop_conv", conv_start, 1);

      // rd_done coincides with timer expiry
      repeat (4) tick();
      tick();
      chk("rd2_req", rd_req, 1);
      repeat (6) tick();
      rd_done = 1; tick(); rd_done = 0;
      exp_cnt++;
      chk("sim_cnt", sample_cnt, exp_cnt);
      chk("sim_no_err", rd_err, 0);
      chk("sim_rdreq", rd_req, 0);
      repeat (3) tick();
      tick();
      chk("loop2_conv", conv_start, 1);

      // Read never completes
      repeat (4) tick();
      tick();
      repeat (6) tick();
      chk("to_pre_err", rd_err, 0);
      chk("to_pre_req", rd_req, 1);
      tick();
`ifdef TEMPSENS_SEQ_RDTO_EN
      exp_err = 1;
      chk("to_err", rd_err, 1);
      chk("to_rdreq", rd_req, 0);
      chk("to_cnt", sample_cnt, exp_cnt);
      chk("to_gap", timer_wait, 2);
`else
      exp_err = 0;
      chk("hold_no_err", rd_err, 0);
      chk("hold_rdreq", rd_req, 1);
      rd_done = 1; tick(); rd_done = 0;
      exp_cnt++;
      chk("hold_cnt", sample_cnt, exp_cnt);
      chk("hold_gap", timer_wait, 2);
`endif
      repeat (3) tick();
      tick();
      chk("loop3_conv", conv_start, 1);

      // Abort in CONV_WAIT
      tick();
      abort = 1; start = 0;
      tick(); abort = 0;
      chk("ab_busy", busy, 0);
      chk("ab_trst", timer_rst, 1);
      chk("ab_twait", timer_wait, 0);
      chk("ab_err_hold", rd_err, exp_err);
      chk("ab_cnt_hold", sample_cnt, exp_cnt);
      seen = 0;
      repeat (8) begin tick(); seen |= conv_start | rd_req | busy; end
      chk("ab_quiet", seen, 0);

      // Restart, then reset in RD_WAIT
      start = 1;
      tick();
      chk("rs_busy", busy, 1);
      chk("rs_err_clr", rd_err, 0);
      repeat (5) tick();
      tick();
      chk("rs_conv", conv_start, 1);
      repeat (4) tick();
      tick();
      tick();
      chk("rs_rdwait", rd_req, 1);
      RST_N = 0; tick(); RST_N = 1;
      chk_reset_vals("mid_rst");
      tick();
      chk("restart_busy", busy, 1);
      chk("restart_twait", timer_wait, 4);

      // Counter wrap
      repeat (5) tick();
      tick();
      repeat (4) tick();
      tick();
      tick();
      chk("wrap_rdwait", rd_req, 1);
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      rd_done = 1; tick(); rd_done = 0;
      chk("wrap_cnt", sample_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
